singlecycle_run_ctrl: RTL and testbench
=======================================

Name: singlecycle_run_ctrl

Overview:
Run controller that sequences the single-cycle processor through test programs. It holds the processor in reset, releases it at a programmed start PC, and watches currentpc for an end-PC condition. At the end PC it captures MemtoRegOut and reports done. A watchdog aborts runaway programs. A continue mode lets a second program run back-to-back without re-resetting the processor.

Parameters:
RESET_CYCLES, 2, clock edges proc_resetl is held low in RESET state (legal range 1..15)
CNT_W, 16, width of cycle counter and watchdog limit

Ports:
CLK  in  1  system clock, all state updates on rising edge
resetl  in  1  asynchronous active-low reset
start  in  1  single-cycle request to launch a run; honoured only in IDLE or STOP
cont  in  1  sampled with start; 1 = continue without processor reset (honoured only in STOP)
abort  in  1  forces IDLE from any state
start_pc_in  in  64  PC driven to processor on reset runs
end_pc  in  64  completion threshold, unsigned compare
max_cycles  in  CNT_W  watchdog limit in RUN edges; 0 = disabled
proc_currentpc  in  64  processor currentpc
proc_memtoreg  in  64  processor MemtoRegOut
proc_resetl  out  1  registered active-low reset to processor
proc_startpc  out  64  registered startpc to processor
busy  out  1  high in RESET and RUN
done  out  1  one-cycle pulse after successful completion
timeout  out  1  sticky watchdog-expired flag
result  out  CNT_W→64  captured MemtoRegOut (64 bits)
cycle_count  out  CNT_W  RUN edges elapsed in current or last run

Behaviour:
- Async reset (resetl=0): state=IDLE, proc_resetl=0, proc_startpc=0, busy=0, done=0, timeout=0, result=0, cycle_count=0, latched end_pc/max=0.
- States: IDLE(proc held in reset), RESET, RUN, STOP(proc free-running, not monitored).
- Priority every edge: abort > start acceptance > state action. abort: next state IDLE, proc_resetl=0, done not asserted, result/cycle_count/timeout hold.
- Start acceptance (IDLE or STOP, start=1): latch end_pc and max_cycles, clear cycle_count and timeout.
  - If cont=0 or state is IDLE: load proc_startpc<=start_pc_in, proc_resetl<=0, reset-counter<=RESET_CYCLES, go to RESET.
  - If cont=1 and state is STOP: go directly to RUN; proc_resetl stays 1 and proc_startpc is unchanged.
- start in RESET/RUN is ignored; no queueing.
- RESET: decrement the counter each edge. On the edge where it reaches 0, set proc_resetl<=1 and go to RUN. proc_resetl is low for exactly RESET_CYCLES edges after acceptance.
- RUN, each edge: cycle_count<=cycle_count+1, saturating at all-ones. Then, using pre-edge values:
  - If proc_currentpc >= end_pc_q: result<=proc_memtoreg, done<=1 for one cycle, go to STOP.
  - Else if max_q!=0 and cycle_count+1==max_q: timeout<=1, proc_resetl<=0, go to IDLE.
  - Completion wins over timeout on the same edge.
- STOP: proc_resetl=1, counters frozen, busy=0.
- done is 0 in every cycle except the one following a completion edge.
- Reset mid-operation: asynchronous return to reset values. The processor is re-held in reset immediately.

Test Plan:
- Reset: assert resetl=0 mid-RUN → all outputs zero combinationally-after-reset; proc_resetl=0 while idle.
- Program 1: processor model (PC<=startpc while proc_resetl=0, else PC+4; memtoreg=0xF at PC≥0x30), start, cont=0, start_pc=0, end_pc=0x30, max=255 → proc_resetl low exactly 2 edges, done pulse after 13 RUN edges, cycle_count=13, result=0xF, state STOP.
- Continue: from STOP, start, cont=1, end_pc=0x5C, model memtoreg=0x123456789ABCDEF0 at PC≥0x5C → proc_resetl never drops, done pulses once, result=0x123456789ABCDEF0.
- Watchdog: end_pc=0x1000, max=8 → after 8 RUN edges timeout=1, cycle_count=8, proc_resetl=0, no done; next start clears timeout.
- Abort/ignore: start during RUN ignored (end_pc_q unchanged); abort at RUN edge 3 → IDLE next edge, no done, result unchanged.
- Boundary: start_pc=0x40, end_pc=0x40 → completes on first RUN edge with cycle_count=1. Max_cycles=0 with unreachable end_pc → no timeout and cycle_count saturates at 0xFFFF.

Source files
------------

// File: rtl/singlecycle_run_ctrl.sv
// Run controller for the single-cycle processor: holds it in reset, releases it at a
// start PC, watches currentpc for the end PC, captures MemtoRegOut, and runs a watchdog.
//
// state | meaning
// IDLE  | processor held in reset, waiting for start
// RESET | processor reset asserted, counting down RESET_CYCLES edges
// RUN   | processor running, end-PC and watchdog monitored
// STOP  | processor free-running, not monitored; continue start allowed
module singlecycle_run_ctrl #(
  parameter int RESET_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             CLK,
  input  logic             resetl,
  input  logic             start,
  input  logic             cont,
  input  logic             abort,
  input  logic [63:0]      start_pc_in,
  input  logic [63:0]      end_pc,
  input  logic [CNT_W-1:0] max_cycles,
  input  logic [63:0]      proc_currentpc,
  input  logic [63:0]      proc_memtoreg,
  output logic             proc_resetl,
  output logic [63:0]      proc_startpc,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [63:0]      result,
  output logic [CNT_W-1:0] cycle_count
);

  typedef enum logic [1:0] {IDLE, RESET, RUN, STOP} state_t;

  localparam logic [3:0] RST_LOAD = 4'(RESET_CYCLES);

  state_t           state;
  logic [3:0]       rst_cnt;
  logic [63:0]      end_pc_q;
  logic [CNT_W-1:0] max_q;
  logic [CNT_W-1:0] cnt_inc;
  logic             can_start;

  assign cnt_inc   = cycle_count + 1'b1;
  assign can_start = start && ((state == IDLE) || (state == STOP));
  assign busy      = (state == RESET) || (state == RUN);

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      state        <= IDLE;
      rst_cnt      <= '0;
      end_pc_q     <= '0;
      max_q        <= '0;
      proc_resetl  <= 1'b0;
      proc_startpc <= '0;
      done         <= 1'b0;
      timeout      <= 1'b0;
      result       <= '0;
      cycle_count  <= '0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state       <= IDLE;
        proc_resetl <= 1'b0;
      end else if (can_start) begin
        end_pc_q    <= end_pc;
        max_q       <= max_cycles;
        cycle_count <= '0;
        timeout     <= 1'b0;
        if (!cont || (state == IDLE)) begin
          proc_startpc <= start_pc_in;
          proc_resetl  <= 1'b0;
          rst_cnt      <= RST_LOAD;
          state        <= RESET;
        end else begin
          state <= RUN;
        end
      end else begin
        case (state)
          IDLE: proc_resetl <= 1'b0;
          RESET: begin
            rst_cnt <= rst_cnt - 4'd1;
            if (rst_cnt == 4'd1) begin
              proc_resetl <= 1'b1;
              state       <= RUN;
            end
          end
          RUN: begin
            if (cycle_count != '1) cycle_count <= cnt_inc;
            // completion is checked first so it wins over an expiring watchdog
            if (proc_currentpc >= end_pc_q) begin
              result <= proc_memtoreg;
              done   <= 1'b1;
              state  <= STOP;
            end else if ((max_q != '0) && (cnt_inc == max_q)) begin
              timeout     <= 1'b1;
              proc_resetl <= 1'b0;
              state       <= IDLE;
            end
          end
          STOP: proc_resetl <= 1'b1;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_singlecycle_run_ctrl.sv
// Scoreboard bench for singlecycle_run_ctrl: directed runs push expected completions or
// timeouts into a queue; a monitor pops and compares when done or timeout appears.
module tb_singlecycle_run_ctrl;

  localparam int CNT_W = 16;

  logic             CLK = 1'b0;
  logic             resetl;
  logic             start, cont, abort;
  logic [63:0]      start_pc_in, end_pc;
  logic [CNT_W-1:0] max_cycles;
  logic [63:0]      proc_currentpc, proc_memtoreg;
  logic             proc_resetl;
  logic [63:0]      proc_startpc;
  logic             busy, done, timeout;
  logic [63:0]      result;
  logic [CNT_W-1:0] cycle_count;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        is_to;
    logic [63:0] res;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb_q[$];

  singlecycle_run_ctrl #(.RESET_CYCLES(2), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .resetl(resetl), .start(start), .cont(cont), .abort(abort),
    .start_pc_in(start_pc_in), .end_pc(end_pc), .max_cycles(max_cycles),
    .proc_currentpc(proc_currentpc), .proc_memtoreg(proc_memtoreg),
    .proc_resetl(proc_resetl), .proc_startpc(proc_startpc), .busy(busy),
    .done(done), .timeout(timeout), .result(result), .cycle_count(cycle_count)
  );

  always #5 CLK = ~CLK;

  // processor model
  always @(posedge CLK) begin
    if (!proc_resetl) proc_currentpc <= proc_startpc;
    else              proc_currentpc <= proc_currentpc + 64'd4;
  end

  always_comb begin
    if (proc_currentpc >= 64'h5C)      proc_memtoreg = 64'h1234_5678_9ABC_DEF0;
    else if (proc_currentpc >= 64'h30) proc_memtoreg = 64'hF;
    else                               proc_memtoreg = 64'h0;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // monitor
  logic tprev = 1'b0;
  always @(negedge CLK) begin
    exp_t e;
    if (resetl && (done || (timeout && !tprev))) begin
      if (sb_q.size() == 0) begin
        check("unexpected_event", {62'd0, timeout, done}, 64'd0);
      end else begin
        e = sb_q.pop_front();
        check("event_kind_timeout", {63'd0, timeout}, {63'd0, e.is_to});
        check("event_kind_done", {63'd0, done}, {63'd0, !e.is_to});
        check("event_cycle_count", {48'd0, cycle_count}, {48'd0, e.cnt});
        if (e.is_to) check("timeout_proc_resetl", {63'd0, proc_resetl}, 64'd0);
        else         check("done_result", result, e.res);
      end
    end
    tprev = timeout;
  end

  task automatic push_exp(input logic is_to, input logic [63:0] res, input logic [15:0] cnt);
    exp_t e;
    e.is_to = is_to; e.res = res; e.cnt = cnt;
    sb_q.push_back(e);
  endtask

  // called on a negedge; returns on the negedge after the accepting edge
  task automatic start_run(input logic [63:0] spc, input logic [63:0] epc,
                           input logic [15:0] mx, input logic c);
    start_pc_in = spc; end_pc = epc; max_cycles = mx; cont = c; start = 1'b1;
    @(negedge CLK);
    start = 1'b0; cont = 1'b0;
  endtask

  task automatic wait_event(input string name, input int budget, output logic min_rl);
    bit seen = 0;
    min_rl = 1'b1;
    for (int i = 0; i < budget; i++) begin
      if (done || timeout) begin seen = 1; break; end
      if (!proc_resetl) min_rl = 1'b0;
      @(negedge CLK);
    end
    if (!seen) check({name, "_wait_expired"}, 64'd0, 64'd1);
  endtask

  initial begin
    logic rl_min;
    int   lowcnt;
    resetl = 1'b0; start = 1'b0; cont = 1'b0; abort = 1'b0;
    start_pc_in = '0; end_pc = '0; max_cycles = '0;
    repeat (3) @(negedge CLK);
    check("rst_proc_resetl", {63'd0, proc_resetl}, 64'd0);
    check("rst_busy_done_to", {61'd0, busy, done, timeout}, 64'd0);
    check("rst_result", result, 64'd0);
    check("rst_cycle_count", {48'd0, cycle_count}, 64'd0);
    check("rst_startpc", proc_startpc, 64'd0);
    resetl = 1'b1;
    repeat (2) @(negedge CLK);
    check("idle_proc_resetl", {63'd0, proc_resetl}, 64'd0);

    // program 1
    push_exp(1'b0, 64'hF, 16'd13);
    start_run(64'h0, 64'h30, 16'd255, 1'b0);
    check("p1_busy", {63'd0, busy}, 64'd1);
    lowcnt = 0;
    for (int g = 0; g < 20; g++) begin
      if (proc_resetl) break;
      lowcnt++;
      @(negedge CLK);
    end
    check("p1_reset_low_edges", lowcnt, 2);
    wait_event("p1", 100, rl_min);

    // continue, issued in the cycle done is seen
    push_exp(1'b0, 64'h1234_5678_9ABC_DEF0, 16'd10);
    start_run(64'h0, 64'h5C, 16'd255, 1'b1);
    check("cont_busy", {63'd0, busy}, 64'd1);
    wait_event("cont", 100, rl_min);
    check("cont_resetl_never_low", {63'd0, rl_min}, 64'd1);
    @(negedge CLK);
    check("cont_done_one_cycle", {63'd0, done}, 64'd0);
    check("stop_busy", {63'd0, busy}, 64'd0);
    check("stop_proc_resetl", {63'd0, proc_resetl}, 64'd1);

    // watchdog
    push_exp(1'b1, 64'h0, 16'd8);
    start_run(64'h0, 64'h1000, 16'd8, 1'b0);
    wait_event("wdog", 100, rl_min);
    check("wdog_busy", {63'd0, busy}, 64'd0);
    check("wdog_result_hold", result, 64'h1234_5678_9ABC_DEF0);
    repeat (3) @(negedge CLK);
    check("wdog_sticky", {63'd0, timeout}, 64'd1);

    // ignored start in RUN, then abort on RUN edge 3
    start_run(64'h0, 64'h30, 16'd0, 1'b0);
    check("restart_clears_timeout", {63'd0, timeout}, 64'd0);
    for (int g = 0; g < 20 && !proc_resetl; g++) @(negedge CLK);
    check("abort_in_run", {62'd0, busy, proc_resetl}, 64'd3);
    start = 1'b1; end_pc = 64'h4;
    @(negedge CLK);
    start = 1'b0;
    @(negedge CLK);
    abort = 1'b1;
    @(negedge CLK);
    abort = 1'b0;
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_proc_resetl", {63'd0, proc_resetl}, 64'd0);
    check("abort_no_done", {63'd0, done}, 64'd0);
    check("abort_cycle_count", {48'd0, cycle_count}, 64'd2);
    check("abort_result", result, 64'h1234_5678_9ABC_DEF0);
    repeat (2) @(negedge CLK);

    // boundary: end PC equal to start PC
    push_exp(1'b0, 64'hF, 16'd1);
    start_run(64'h40, 64'h40, 16'd100, 1'b0);
    check("bnd_startpc", proc_startpc, 64'h40);
    wait_event("bnd", 50, rl_min);
    @(negedge CLK);

    // watchdog disabled, counter saturates
    start_run(64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 16'd0, 1'b0);
    repeat (65600) @(negedge CLK);
    check("sat_cycle_count", {48'd0, cycle_count}, 64'hFFFF);
    check("sat_no_timeout", {63'd0, timeout}, 64'd0);
    check("sat_busy", {63'd0, busy}, 64'd1);

    // async reset mid-run
    #2 resetl = 1'b0;
    #1;
    check("midrst_proc_resetl", {63'd0, proc_resetl}, 64'd0);
    check("midrst_flags", {61'd0, busy, done, timeout}, 64'd0);
    check("midrst_result", result, 64'd0);
    check("midrst_cycle_count", {48'd0, cycle_count}, 64'd0);
    check("midrst_startpc", proc_startpc, 64'd0);
    check("sb_empty", sb_q.size(), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
